// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub
// Two-stage pipelined carry-lookahead adder/subtractor with an internal
// accumulator and valid/ready flow control on both sides.
//
// Parameters
//   WIDTH  operand/result width (2..64)
//   GROUP  bits per first-level lookahead group (last group may be partial)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   request present
//   in_ready   request accepted on this edge when in_valid && in_ready
//   op         00 add, 01 subtract, 10 accumulate, 11 clear accumulator
//   a, b       operands (b ignored for accumulate/clear)
//   cin        carry-in, used by add only
//   out_valid  result present
//   out_ready  downstream accepts result
//   sum        result (modulo 2^WIDTH)
//   cout       carry out of MSB (subtract: 1 = no borrow)
//   ovf        two's-complement signed overflow
module cla_pipe_addsub #(
  parameter int WIDTH = 24,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NG = (WIDTH + GROUP - 1) / GROUP;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_t;

  // Stage 1: conditioned operands
  logic             s1_valid;
  op_t              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_c0;

  logic [WIDTH-1:0] acc;

  // Flow control: a stage may load when its downstream slot is free or
  // being emptied on the same edge.
  logic s2_adv;
  logic s1_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // The accumulator is picked here rather than in S1 so that a run of
  // accumulates always sees the value written by the previous one.
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;

  assign x = s1_a;
  assign y = (s1_op == OP_ACC) ? acc : s1_b;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic [NG:0]      grp_c;
  logic [WIDTH:0]   c;
  logic             term;

  // Every carry is written as a flat sum of products (g AND run of p), so
  // no carry is expressed through another carry at the same level.
  always_comb begin
    // NOTE: every variable gets a value before any branch/loop so no
    // path leaves it unassigned, which would otherwise infer a latch.
    g     = x & y;
    p     = x ^ y;
    grp_g = '0;
    grp_p = '1;
    grp_c = '0;
    c     = '0;
    term  = 1'b0;

    // First level: group generate/propagate
    for (int k = 0; k < NG; k++) begin
      for (int j = 0; j < GROUP; j++) begin
        if (k * GROUP + j < WIDTH) begin
          grp_p[k] = grp_p[k] & p[k*GROUP+j];
          term = g[k*GROUP+j];
          for (int m = 0; m < GROUP; m++) begin
            if (m > j && k * GROUP + m < WIDTH) term = term & p[k*GROUP+m];
          end
          grp_g[k] = grp_g[k] | term;
        end
      end
    end

    // Second level: carry into each group (grp_c[NG] is the final carry)
    for (int k = 0; k <= NG; k++) begin
      for (int j = 0; j < NG; j++) begin
        if (j < k) begin
          term = grp_g[j];
          for (int m = 0; m < NG; m++) begin
            if (m > j && m < k) term = term & grp_p[m];
          end
          grp_c[k] = grp_c[k] | term;
        end
      end
      term = s1_c0;
      for (int m = 0; m < NG; m++) begin
        if (m < k) term = term & grp_p[m];
      end
      grp_c[k] = grp_c[k] | term;
    end

    // Bit carries inside each group, from that group's carry-in
    for (int i = 0; i < WIDTH; i++) begin
      term = grp_c[i/GROUP];
      for (int m = 0; m < GROUP; m++) begin
        if ((i / GROUP) * GROUP + m < i) term = term & p[(i/GROUP)*GROUP+m];
      end
      c[i] = term;
      for (int j = 0; j < GROUP; j++) begin
        if ((i / GROUP) * GROUP + j < i) begin
          term = g[(i/GROUP)*GROUP+j];
          for (int m = 0; m < GROUP; m++) begin
            if (m > j && (i / GROUP) * GROUP + m < i) term = term & p[(i/GROUP)*GROUP+m];
          end
          c[i] = c[i] | term;
        end
      end
    end
    c[WIDTH] = grp_c[NG];
  end

  logic [WIDTH-1:0] s2_sum;
  logic             s2_cout;
  logic             s2_ovf;

  assign s2_sum  = p ^ c[WIDTH-1:0];
  assign s2_cout = c[WIDTH];
  assign s2_ovf  = c[WIDTH] ^ c[WIDTH-1];

  // NOTE: state is assigned with <= so every register samples the values
  // from before the edge; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_op     <= OP_ADD;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_c0     <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      acc       <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_op <= op_t'(op);
          s1_a  <= a;
          s1_b  <= (op_t'(op) == OP_SUB) ? ~b : b;
          case (op_t'(op))
            OP_ADD:  s1_c0 <= cin;
            OP_SUB:  s1_c0 <= 1'b1;
            default: s1_c0 <= 1'b0;
          endcase
        end
      end

      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          if (s1_op == OP_CLR) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
            acc  <= '0;
          end else begin
            sum  <= s2_sum;
            cout <= s2_cout;
            ovf  <= s2_ovf;
            if (s1_op == OP_ACC) acc <= s2_sum;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Self-checking bench for cla_pipe_addsub.
// Directed vectors on a WIDTH=24/GROUP=4 instance feed a scoreboard queue at
// the moment each request is accepted; an independent monitor pops and
// compares whenever a result handshake occurs. Three further instances
// (WIDTH 2, 7, 64) run random traffic with random backpressure against a
// behavioural a+b model.
module tb_cla_pipe_addsub;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] ACC = 2'b10;
  localparam logic [1:0] CLR = 2'b11;
  localparam int N_SWEEP = 10000;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [23:0] a;
  logic [23:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] sum;
  logic        cout;
  logic        ovf;

  int n_checks = 0;
  int n_pass   = 0;
  int stall_cnt = 0;
  int sw_done  = 0;

  typedef struct {
    string       nm;
    logic [23:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  cla_pipe_addsub #(.WIDTH(24), .GROUP(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Called just after a rising edge. Holds the request until accepted,
  // pushing the expected result on the edge that accepts it.
  task automatic send(input logic [1:0] o, input logic [23:0] av, input logic [23:0] bv,
                      input logic ci, input logic [23:0] es, input logic ec,
                      input logic eo, input string nm);
    logic accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    op = o; a = av; b = bv; cin = ci;
    for (int w = 0; w < 50 && !accepted; w++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back('{nm, es, ec, eo});
        accepted = 1'b1;
      end
      @(posedge clk); #1;
      if (!accepted) stall_cnt++;
    end
    in_valid = 1'b0;
    if (!accepted) check({nm, " accept timeout"}, 128'(accepted), 128'(1));
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    check({nm, " drain"}, 128'(exp_q.size()), 128'(0));
  endtask

  // Result monitor: compares on each completed output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected result", 128'(sum), 128'(0));
        check("unexpected result valid", 128'(out_valid), 128'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.nm, " sum"},  128'(sum),  128'(mon_e.sum));
        check({mon_e.nm, " cout"}, 128'(cout), 128'(mon_e.cout));
        check({mon_e.nm, " ovf"},  128'(ovf),  128'(mon_e.ovf));
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = ADD; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("reset out_valid", 128'(out_valid), 128'(0));
    check("reset sum",       128'(sum),       128'(0));
    check("reset cout",      128'(cout),      128'(0));
    check("reset ovf",       128'(ovf),       128'(0));
    check("reset in_ready",  128'(in_ready),  128'(1));

    // Full carry chain; also latency: empty after the accept edge,
    // valid after the following edge.
    send(ADD, 24'hFFFFFF, 24'h000001, 1'b0, 24'h000000, 1'b1, 1'b0, "carry chain");
    check("latency after accept edge", 128'(out_valid), 128'(0));
    @(posedge clk); #1;
    check("latency second edge", 128'(out_valid), 128'(1));

    send(SUB, 24'h000005, 24'h000007, 1'b1, 24'hFFFFFE, 1'b0, 1'b0, "sub 5-7");
    send(ADD, 24'h7FFFFF, 24'h000001, 1'b0, 24'h800000, 1'b0, 1'b1, "add pos ovf");
    send(ADD, 24'h123456, 24'h111111, 1'b1, 24'h234568, 1'b0, 1'b0, "add cin");
    send(SUB, 24'h00000A, 24'h000003, 1'b0, 24'h000007, 1'b1, 1'b0, "sub 10-3");
    send(ADD, 24'h800000, 24'h800000, 1'b0, 24'h000000, 1'b1, 1'b1, "add neg ovf");
    send(SUB, 24'h800000, 24'h000001, 1'b0, 24'h7FFFFF, 1'b1, 1'b1, "sub min-1");
    send(CLR, 24'h000055, 24'h000066, 1'b1, 24'h000000, 1'b0, 1'b0, "clear");
    drain("directed");

    // Back-to-back accumulates at full rate
    stall_cnt = 0;
    send(CLR, 24'h0, 24'h0,   1'b0, 24'd0,  1'b0, 1'b0, "stream clr");
    send(ACC, 24'd3, 24'hABC, 1'b1, 24'd3,  1'b0, 1'b0, "stream acc3");
    send(ACC, 24'd4, 24'h123, 1'b0, 24'd7,  1'b0, 1'b0, "stream acc4");
    send(ACC, 24'd5, 24'h0,   1'b0, 24'd12, 1'b0, 1'b0, "stream acc5");
    check("stream no stall", 128'(stall_cnt), 128'(0));
    drain("stream");

    // Adds interleaved between accumulates leave acc untouched
    send(CLR, 24'h0, 24'h0, 1'b0, 24'd0,  1'b0, 1'b0, "iso clr");
    send(ACC, 24'd3, 24'h0, 1'b0, 24'd3,  1'b0, 1'b0, "iso acc3");
    send(ADD, 24'd1, 24'd1, 1'b0, 24'd2,  1'b0, 1'b0, "iso add1");
    send(ACC, 24'd4, 24'h0, 1'b0, 24'd7,  1'b0, 1'b0, "iso acc4");
    send(ADD, 24'd1, 24'd1, 1'b0, 24'd2,  1'b0, 1'b0, "iso add2");
    send(ACC, 24'd5, 24'h0, 1'b0, 24'd12, 1'b0, 1'b0, "iso acc5");
    drain("isolation");

    // Accumulator crossing into the sign bit
    send(CLR, 24'h0,      24'h0, 1'b0, 24'h000000, 1'b0, 1'b0, "accovf clr");
    send(ACC, 24'h7FFFFF, 24'h0, 1'b0, 24'h7FFFFF, 1'b0, 1'b0, "accovf acc1");
    send(ACC, 24'h000001, 24'h0, 1'b0, 24'h800000, 1'b0, 1'b1, "accovf acc2");
    drain("acc ovf");

    // Backpressure: stall the output while three requests are offered
    out_ready = 1'b0;
    send(ADD, 24'd1,  24'd2,  1'b0, 24'd3,  1'b0, 1'b0, "bp r1");
    send(ADD, 24'd10, 24'd20, 1'b0, 24'd30, 1'b0, 1'b0, "bp r2");
    check("bp in_ready low", 128'(in_ready),  128'(0));
    check("bp out_valid",    128'(out_valid), 128'(1));
    check("bp sum head",     128'(sum),       128'(3));
    fork
      send(SUB, 24'd100, 24'd1, 1'b0, 24'd99, 1'b1, 1'b0, "bp r3");
      begin
        repeat (2) begin
          @(negedge clk);
          check("bp hold sum",      128'(sum),       128'(3));
          check("bp hold valid",    128'(out_valid), 128'(1));
          check("bp hold in_ready", 128'(in_ready),  128'(0));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain("backpressure");

    // Reset with both stages full and a request offered during reset
    out_ready = 1'b0;
    send(ACC, 24'd100, 24'h0, 1'b0, 24'd0, 1'b0, 1'b0, "rst flushed1");
    send(ACC, 24'd1,   24'h0, 1'b0, 24'd0, 1'b0, 1'b0, "rst flushed2");
    check("rst pre in_ready", 128'(in_ready), 128'(0));
    rst = 1'b1; in_valid = 1'b1; op = ADD; a = 24'd1; b = 24'd1; cin = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    check("rst out_valid", 128'(out_valid), 128'(0));
    check("rst sum",       128'(sum),       128'(0));
    check("rst cout",      128'(cout),      128'(0));
    check("rst ovf",       128'(ovf),       128'(0));
    check("rst in_ready",  128'(in_ready),  128'(1));
    @(posedge clk); #1;
    check("rst request not accepted", 128'(out_valid), 128'(0));
    out_ready = 1'b1;
    send(ACC, 24'd9, 24'h0, 1'b0, 24'd9, 1'b0, 1'b0, "post-rst acc9");
    drain("reset");
    repeat (4) @(posedge clk);

    for (int i = 0; i < 60000 && sw_done < 3; i++) @(posedge clk);
    check("sweeps finished", 128'(sw_done), 128'(3));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Width sweep with random ops, random backpressure and a behavioural model
  for (genvar gi = 0; gi < 3; gi++) begin : sw
    localparam int W = (gi == 0) ? 2 : ((gi == 1) ? 7 : 64);

    logic         rst_s;
    logic         in_valid_s;
    logic         in_ready_s;
    logic [1:0]   op_s;
    logic [W-1:0] a_s;
    logic [W-1:0] b_s;
    logic         cin_s;
    logic         out_valid_s;
    logic         out_ready_s;
    logic [W-1:0] sum_s;
    logic         cout_s;
    logic         ovf_s;
    logic [W+1:0] q[$];

    cla_pipe_addsub #(.WIDTH(W), .GROUP(4)) dut_s (
      .clk(clk), .rst(rst_s),
      .in_valid(in_valid_s), .in_ready(in_ready_s),
      .op(op_s), .a(a_s), .b(b_s), .cin(cin_s),
      .out_valid(out_valid_s), .out_ready(out_ready_s),
      .sum(sum_s), .cout(cout_s), .ovf(ovf_s)
    );

    initial begin
      logic         hs;
      logic [63:0]  ra;
      logic [63:0]  rb;
      logic [W-1:0] y;
      logic [W-1:0] acc_m;
      logic         c;
      logic [W:0]   r;
      int           n;
      rst_s = 1'b1; in_valid_s = 1'b0; out_ready_s = 1'b1;
      op_s = 2'b00; a_s = '0; b_s = '0; cin_s = 1'b0;
      acc_m = '0; hs = 1'b0; n = 0;
      repeat (2) @(posedge clk);
      #1 rst_s = 1'b0;
      for (int cyc = 0; cyc < 40000 && n < N_SWEEP; cyc++) begin
        @(posedge clk); #1;
        out_ready_s = ($urandom_range(0, 3) != 0);
        if (hs || !in_valid_s) begin
          ra = {$urandom(), $urandom()};
          rb = {$urandom(), $urandom()};
          op_s  = 2'($urandom_range(0, 3));
          a_s   = ra[W-1:0];
          b_s   = rb[W-1:0];
          cin_s = 1'($urandom_range(0, 1));
          in_valid_s = 1'b1;
          hs = 1'b0;
        end
        @(negedge clk);
        if (in_ready_s) begin
          case (op_s)
            ADD:     begin y = b_s;   c = cin_s; end
            SUB:     begin y = ~b_s;  c = 1'b1;  end
            ACC:     begin y = acc_m; c = 1'b0;  end
            default: begin y = '0;    c = 1'b0;  end
          endcase
          r = {1'b0, a_s} + {1'b0, y} + {{W{1'b0}}, c};
          if (op_s == CLR) begin
            q.push_back('0);
            acc_m = '0;
          end else begin
            q.push_back({(a_s[W-1] == y[W-1]) && (r[W-1] != a_s[W-1]), r[W], r[W-1:0]});
            if (op_s == ACC) acc_m = r[W-1:0];
          end
          n++;
          hs = 1'b1;
        end
      end
      @(posedge clk); #1;
      in_valid_s = 1'b0;
      out_ready_s = 1'b1;
      for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
      #1;
      check($sformatf("sweep w%0d issued", W), 128'(n), 128'(N_SWEEP));
      check($sformatf("sweep w%0d drain", W), 128'(q.size()), 128'(0));
      sw_done++;
    end

    always @(negedge clk) begin
      if (!rst_s && out_valid_s && out_ready_s) begin
        if (q.size() == 0) check($sformatf("sweep w%0d unexpected", W), 128'(out_valid_s), 128'(0));
        else check($sformatf("sweep w%0d result", W), 128'({ovf_s, cout_s, sum_s}), 128'(q.pop_front()));
      end
    end
  end

endmodule
